mux_scan_sel: RTL and testbench

- Parametrised, registered N:1 selector for the delay-PUF datapath. Successor to the fixed 16:1 combinational mux.
- Adds a registered select, a settle window after every select change, a valid/ack handshake, and an auto-scan mode that steps through all inputs in order.
- Sits between the delay-line/RO array outputs and the arbiter/counter stage, so downstream logic only samples a path once it has settled.

---
 rtl/mux_scan_sel_pkg.sv | 13 +
 rtl/mux_scan_sel_settle_counter.sv | 29 ++
 rtl/mux_scan_sel.sv | 134 +++++++++++++
 tb/tb_mux_scan_sel.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_sel_pkg.sv
// Shared types for the delay-PUF path selector: FSM states and mode encoding.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    VALID  = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_sel_settle_counter.sv
// Up/down counter with clear, load and terminal-count flag; shared with the arbiter stage.
module settle_counter #(
  parameter int W      = 3,
  parameter bit UP     = 1'b1,
  parameter int TC_VAL = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  localparam logic [W-1:0] TC_L = W'(TC_VAL);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en)   cnt <= UP ? cnt + 1'b1 : cnt - 1'b1;
  end

  assign tc = (cnt == TC_L);

endmodule

// File: rtl/mux_scan_sel.sv
// Registered N:1 path selector with settle window, valid/ack handshake and auto-scan.
module mux_scan_sel
  import mux_scan_pkg::*;
#(
  parameter  int N_IN       = 16,
  parameter  int SETTLE_CYC = 4,
  localparam int SEL_W      = $clog2(N_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  in,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel_in,
  input  logic             sel_load,
  input  logic             start,
  input  logic             ack,
  input  logic             abort,
  output logic             out,
  output logic [SEL_W-1:0] sel_cur,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic             sel_err
);

  localparam int               CNT_W   = $clog2(SETTLE_CYC + 1);
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_IN - 1);

  state_t           state, state_n;
  logic [SEL_W-1:0] sel_n;
  logic             mode_q, mode_n;
  logic             restart, done_n, err_n, cnt_tc, sel_ok;

  assign sel_ok = (int'(sel_in) < N_IN);

  // Counter restarts on every entry into SETTLE and is held at zero outside it.
  settle_counter #(.W(CNT_W), .UP(1'b1), .TC_VAL(SETTLE_CYC - 1)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (restart || (state_n != SETTLE)),
    .load     (1'b0),
    .en       (state == SETTLE),
    .load_val ('0),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_n = state;
    sel_n   = sel_cur;
    mode_n  = mode_q;
    restart = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (mode == MODE_SCAN) begin
            if (start) begin
              sel_n   = '0;
              mode_n  = MODE_SCAN;
              restart = 1'b1;
              state_n = SETTLE;
            end
          end else if (sel_load) begin
            if (sel_ok) begin
              sel_n   = sel_in;
              mode_n  = MODE_MANUAL;
              restart = 1'b1;
              state_n = SETTLE;
            end else begin
              err_n = 1'b1;
            end
          end
        end
        SETTLE: begin
          if (mode_q == MODE_MANUAL && sel_load && sel_ok) begin
            sel_n   = sel_in;
            restart = 1'b1;
          end else begin
            err_n = (mode_q == MODE_MANUAL) && sel_load;
            if (cnt_tc) state_n = VALID;
          end
        end
        VALID: begin
          if (mode_q == MODE_SCAN) begin
            if (ack) begin
              if (sel_cur == SEL_MAX) begin
                done_n  = 1'b1;
                state_n = IDLE;
              end else begin
                sel_n   = sel_cur + 1'b1;
                restart = 1'b1;
                state_n = SETTLE;
              end
            end
          end else if (sel_load) begin
            if (sel_ok) begin
              sel_n   = sel_in;
              restart = 1'b1;
              state_n = SETTLE;
            end else begin
              err_n = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel_cur <= '0;
      mode_q  <= MODE_MANUAL;
      out     <= 1'b0;
      done    <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      state   <= state_n;
      sel_cur <= sel_n;
      mode_q  <= mode_n;
      out     <= in[sel_cur];
      done    <= done_n;
      sel_err <= err_n;
    end
  end

  assign valid = (state == VALID);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mux_scan_sel.sv
// Bench for mux_scan_sel: a 16-input/4-cycle and a 10-input/1-cycle instance share stimulus.
module tb_mux_scan_sel;

  localparam int SC16 = 4;
  localparam int SC10 = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_v;
  logic        mode, sel_load, start, ack, abort;
  logic [3:0]  sel_in;
  logic        o16, v16, b16, d16, e16;
  logic        o10, v10, b10, d10, e10;
  logic [3:0]  s16, s10;

  int errors = 0;
  int checks = 0;
  int dcnt   = 0;

  always #5 clk = ~clk;

  mux_scan_sel #(.N_IN(16), .SETTLE_CYC(SC16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in(in_v), .mode(mode), .sel_in(sel_in),
    .sel_load(sel_load), .start(start), .ack(ack), .abort(abort),
    .out(o16), .sel_cur(s16), .valid(v16), .busy(b16), .done(d16), .sel_err(e16)
  );

  mux_scan_sel #(.N_IN(10), .SETTLE_CYC(SC10)) dut10 (
    .clk(clk), .rst_n(rst_n), .in(in_v[9:0]), .mode(mode), .sel_in(sel_in),
    .sel_load(sel_load), .start(start), .ack(ack), .abort(abort),
    .out(o10), .sel_cur(s10), .valid(v10), .busy(b10), .done(d10), .sel_err(e10)
  );

  // Model: busy flag plus cycles remaining until the selected path is settled.
  typedef struct {
    bit busy;
    bit scan;
    int sel;
    int left;
    bit out;
    bit done;
    bit err;
  } mdl_t;

  mdl_t m16, m10;

  function automatic mdl_t step(mdl_t m, int n, int sc);
    mdl_t r = m;
    r.out  = in_v[m.sel];
    r.done = 0;
    r.err  = 0;
    if (abort) begin
      r.busy = 0;
      r.left = 0;
    end else if (!m.busy) begin
      if (mode && start) begin
        r.sel = 0; r.scan = 1; r.busy = 1; r.left = sc;
      end else if (!mode && sel_load) begin
        if (int'(sel_in) < n) begin
          r.sel = int'(sel_in); r.scan = 0; r.busy = 1; r.left = sc;
        end else r.err = 1;
      end
    end else if (m.left > 0) begin
      if (!m.scan && sel_load && int'(sel_in) < n) begin
        r.sel = int'(sel_in); r.left = sc;
      end else begin
        r.err  = !m.scan && sel_load;
        r.left = m.left - 1;
      end
    end else if (m.scan) begin
      if (ack) begin
        if (m.sel == n - 1) begin
          r.done = 1; r.busy = 0;
        end else begin
          r.sel = m.sel + 1; r.left = sc;
        end
      end
    end else if (sel_load) begin
      if (int'(sel_in) < n) begin
        r.sel = int'(sel_in); r.left = sc;
      end else r.err = 1;
    end
    return r;
  endfunction

  function automatic logic [8:0] ev(mdl_t m);
    return {m.out, 4'(m.sel), (m.busy && m.left == 0), m.busy, m.done, m.err};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m16 <= '{default: 0};
      m10 <= '{default: 0};
    end else begin
      m16 <= step(m16, 16, SC16);
      m10 <= step(m10, 10, SC10);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model16", {o16, s16, v16, b16, d16, e16}, ev(m16));
    chk("model10", {o10, s10, v10, b10, d10, e10}, ev(m10));
  end

  always @(negedge clk) if (d16) dcnt <= dcnt + 1;

  task automatic wait_valid();
    int n = 0;
    while (!v16 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", v16, 1);
  endtask

  initial begin
    in_v = 16'hA5C3; mode = 0; sel_in = 0; sel_load = 0; start = 0; ack = 0; abort = 0;
    @(negedge clk);
    chk("reset", {o16, s16, v16, b16, d16, e16}, 0);
    rst_n = 1;
    @(negedge clk);

    // Manual load of path 5, then handshake corner cases, then path 1.
    sel_in = 5; sel_load = 1;
    @(negedge clk); sel_load = 0;
    chk("ld_sel", s16, 5);
    chk("ld_busy", {v16, b16}, 2'b01);
    repeat (3) begin @(negedge clk); chk("settle_v", v16, 0); end
    @(negedge clk);
    chk("valid_up", v16, 1);
    chk("out5", o16, 0);
    ack = 1;
    @(negedge clk); ack = 0;
    chk("man_ack", v16, 1);
    sel_load = 1;
    @(negedge clk); sel_load = 0;
    chk("reld_same", {s16, v16}, {4'd5, 1'b0});
    wait_valid();
    sel_in = 1; sel_load = 1;
    @(negedge clk); sel_load = 0;
    chk("drop", {s16, v16}, {4'd1, 1'b0});
    @(negedge clk);
    chk("out1", o16, 1);

    // Illegal select only for the 10-input instance.
    abort = 1;
    @(negedge clk); abort = 0;
    chk("abort_idle", {b16, b10}, 2'b00);
    sel_in = 12; sel_load = 1;
    @(negedge clk); sel_load = 0;
    chk("err10", {e10, s10, b10}, {1'b1, 4'd1, 1'b0});
    chk("legal16", {e16, s16, b16}, {1'b0, 4'd12, 1'b1});
    @(negedge clk);
    chk("err_pulse", e10, 0);
    abort = 1;
    @(negedge clk); abort = 0;

    // Start wins over sel_load in scan mode; mode flips to manual while busy.
    mode = 1; start = 1; sel_load = 1; sel_in = 9;
    @(negedge clk); start = 0; sel_load = 0; mode = 0;
    chk("prio_sel", {s16, b16}, {4'd0, 1'b1});
    for (int k = 0; k < 16; k++) begin
      wait_valid();
      chk("sweep_sel", s16, k);
      chk("sweep_out", o16, in_v[k]);
      ack = 1;
      if (k == 5) begin start = 1; sel_load = 1; sel_in = 2; end
      @(negedge clk); ack = 0; start = 0; sel_load = 0;
    end
    chk("done", {d16, s16, b16, v16}, {1'b1, 4'd15, 2'b00});
    @(negedge clk);
    chk("done_pulse", d16, 0);
    chk("done_cnt", dcnt, 1);

    // Abort in SETTLE at path 7, then restart from 0.
    mode = 1; start = 1;
    @(negedge clk); start = 0;
    for (int k = 0; k < 7; k++) begin
      wait_valid();
      ack = 1;
      @(negedge clk); ack = 0;
    end
    chk("ab_pre", {s16, v16, b16}, {4'd7, 2'b01});
    abort = 1;
    @(negedge clk); abort = 0;
    chk("ab_state", {s16, v16, b16, d16}, {4'd7, 3'b000});
    repeat (3) @(negedge clk);
    chk("ab_nodone", dcnt, 1);
    start = 1;
    @(negedge clk); start = 0;
    chk("restart", {s16, b16}, {4'd0, 1'b1});

    // Asynchronous reset mid-cycle while scanning.
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("async16", {o16, s16, v16, b16, d16, e16}, 0);
    chk("async10", {o10, s10, v10, b10, d10, e10}, 0);
    @(negedge clk);
    rst_n = 1; mode = 0;
    repeat (3) @(negedge clk);
    chk("post_rst", {b16, s16}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
